// File: rtl/board_pkg.sv
// Shared board definitions: 2-bit cell encoding, row geometry and the row reader state type.
package board_pkg;

  localparam int ROW_LANES = 16;
  localparam int CELL_W    = 2;

  localparam logic [CELL_W-1:0] CELL_EMPTY   = 2'b00;
  localparam logic [CELL_W-1:0] CELL_BLACK   = 2'b01;
  localparam logic [CELL_W-1:0] CELL_WHITE   = 2'b10;
  localparam logic [CELL_W-1:0] CELL_INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } reader_state_t;

endpackage

// File: rtl/board_row_reader_next_lane_finder.sv
// Combinational search for the lowest non-empty lane at or above a starting lane.
module next_lane_finder
  import board_pkg::*;
(
  input  logic [ROW_LANES*CELL_W-1:0] row_i,
  input  logic [3:0]                  from_i,
  input  logic                        inclusive_i,
  output logic                        found_o,
  output logic [3:0]                  lane_o
);

  // Scanning downward lets the lowest qualifying lane overwrite any higher hit.
  always_comb begin
    found_o = 1'b0;
    lane_o  = 4'd0;
    for (int i = ROW_LANES - 1; i >= 0; i--) begin
      if ((row_i[i*CELL_W +: CELL_W] != CELL_EMPTY) &&
          ((4'(i) > from_i) || (inclusive_i && (4'(i) == from_i)))) begin
        found_o = 1'b1;
        lane_o  = 4'(i);
      end
    end
  end

endmodule

// File: rtl/board_row_reader.sv
// Streams a snapshotted 16-lane row one cell per handshake and counts non-empty cells.
// Define BOARD_ROW_READER_SKIP_EMPTY_EN to skip empty lanes at zero cycle cost.
module board_row_reader
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] row_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  cell_out,
  output logic [3:0]  index_out,
  output logic        busy,
  output logic        done,
  output logic [4:0]  occupied_count
);

  reader_state_t state_q;
  logic [31:0]   snap_q;
  logic [3:0]    idx_q;
  logic [4:0]    count_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  logic [1:0]    curCell;
  logic [3:0]    nextIdx_d;
  logic          nextLast_d;
  logic [3:0]    startIdx_d;
  logic          startEmpty_d;

  assign curCell = snap_q[{idx_q, 1'b0} +: 2];

`ifdef BOARD_ROW_READER_SKIP_EMPTY_EN
  logic       startFound;
  logic       nextFound;

  next_lane_finder u_start_finder (
    .row_i       (row_in),
    .from_i      (4'd0),
    .inclusive_i (1'b1),
    .found_o     (startFound),
    .lane_o      (startIdx_d)
  );

  next_lane_finder u_next_finder (
    .row_i       (snap_q),
    .from_i      (idx_q),
    .inclusive_i (1'b0),
    .found_o     (nextFound),
    .lane_o      (nextIdx_d)
  );

  assign startEmpty_d = !startFound;
  assign nextLast_d   = !nextFound;
`else
  assign startIdx_d   = 4'd0;
  assign startEmpty_d = 1'b0;
  assign nextIdx_d    = idx_q + 4'd1;
  assign nextLast_d   = (idx_q == 4'(ROW_LANES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q  <= row_in;
            count_q <= '0;
            busy_q  <= 1'b1;
            idx_q   <= startIdx_d;
            if (startEmpty_d) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= SCAN;
              valid_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (out_ready) begin
            count_q <= count_q + 5'(curCell != CELL_EMPTY);
            if (nextLast_d) begin
              state_q <= FINISH;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= nextIdx_d;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Cell output is forced empty outside a scan so idle/reset shows 00.
  assign out_valid      = valid_q;
  assign cell_out       = valid_q ? curCell : CELL_EMPTY;
  assign index_out      = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign occupied_count = count_q;

endmodule

// File: doc/board_row_reader.md
# board_row_reader

Sequential 16-to-1 reader for a packed row of sixteen 2-bit cells, the read-side counterpart of the 1-to-16 row writer that scatters a 2-bit value into one of sixteen lanes. On a start pulse it snapshots the 32-bit row and streams cells out one per accepted handshake, lane 0 first, with the lane index. It reports completion and a count of non-empty cells. It sits between the board storage and the line-evaluation logic.

## Interface
Parameters: none; the row geometry is fixed at 16 lanes × 2 bits.

Ports:
- clk  input  1  single clock, all state on rising edge
- resetn  input  1  synchronous reset, active-low
- start  input  1  request a scan of row_in; accepted only while busy=0
- row_in  input  32  lane k occupies row_in[2k+1:2k]
- out_ready  input  1  consumer accepts the current cell
- out_valid  output  1  cell_out / index_out are valid
- cell_out  output  2  cell value of the current lane
- index_out  output  4  current lane number, 0..15
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse after the last cell is accepted
- occupied_count  output  5  number of non-empty cells accepted in the last scan, 0..16

## Operation
- Cell encoding: 00 empty, 01 black, 10 white, 11 invalid. Invalid cells are passed through unchanged and counted as non-empty.
- States: IDLE, SCAN, FINISH.
- IDLE: busy=0, out_valid=0. When start=1, the block latches row_in into the snapshot register, clears occupied_count, sets index to 0 (or to the first non-empty lane; see Configuration), and moves to SCAN.
- SCAN: out_valid=1, cell_out = snapshot lane[index], index_out = index. The output stays stable while out_ready=0.
- Handshake: a cell transfers when out_valid and out_ready are both high on a clock edge. On transfer, occupied_count increments if cell_out≠00. The index then advances to the next lane, or the state moves to FINISH if the transferred lane is the last one.
- FINISH: out_valid=0, done=1 for exactly one cycle, then IDLE. occupied_count holds its value until the next accepted start.
- start is ignored while busy=1 or in FINISH. row_in changes after acceptance have no effect.
- Reset mid-scan: the scan is abandoned and all outputs return to their reset values. No done pulse is generated.
- Reset values: out_valid=0, cell_out=00, index_out=0, busy=0, done=0, occupied_count=0, state IDLE, snapshot=0.

## Timing
- Start is accepted at edge N. At edge N+1 the block is in SCAN, and out_valid=1 is visible in cycle N+1.
- With out_ready held at 1, one cell transfers per cycle: 16 cells in cycles N+1..N+16, done in cycle N+17, and busy=0 from cycle N+18. A new start can be accepted in cycle N+18.
- No output depends combinationally on out_ready or start. All outputs are registered or are decoded from registered state.
- Index arithmetic is 4-bit. The transfer at index 15 never wraps to 0; it goes to FINISH.

## Configuration
- Macro: BOARD_ROW_READER_SKIP_EMPTY_EN.
- Defined:
  - Empty (00) lanes are never presented. Both the start index and the next index are the lowest non-empty lane above the current one, found combinationally in the same cycle, so skipping costs zero cycles.
  - If no non-empty lane remains, the state goes directly to FINISH.
  - An all-empty row goes IDLE→FINISH, with done one cycle after start, zero transfers, and occupied_count=0.
- Undefined: all 16 lanes are presented in order, including empty ones.

## Structure
- The shared package board_pkg holds:
  - cell encoding constants CELL_EMPTY, CELL_BLACK, CELL_WHITE, CELL_INVALID
  - ROW_LANES=16, CELL_W=2
  - the reader state enum {IDLE, SCAN, FINISH}
- One sub-module, next_lane_finder. It is purely combinational and maps (snapshot, from_index, inclusive flag) to {found, lane}. It is instantiated only under BOARD_ROW_READER_SKIP_EMPTY_EN.

## Test plan
- Reset and basic scan. Stimulus: reset, then start with row_in=32'hE4E4_E4E4 and out_ready=1. Required: lanes 0..15 emit 00,01,10,11 repeating with index_out 0..15 on consecutive cycles; done 17 cycles after start; occupied_count=12.
- Backpressure. Stimulus: same row, with out_ready toggled 1,0,0,1,… Required: cell_out and index_out are held stable while stalled; there are no duplicated or dropped lanes; occupied_count=12.
- Snapshot isolation and start ignore. Stimulus: change row_in and pulse start during SCAN. Required: the output follows the original snapshot, and there is no restart.
- Reset mid-scan. Stimulus: resetn=0 at index 7. Required: the next cycle shows all outputs at reset values, no done pulse, and a fresh start then scans from index 0.
- Skip mode (macro defined). Stimulus: row_in=32'h4000_0001. Required: exactly two transfers, (index 0, cell 01) then (index 15, cell 01), on back-to-back cycles; occupied_count=2.
- Skip mode with an empty row. Stimulus: row_in=0. Required: done one cycle after start acceptance, out_valid never asserts, occupied_count=0.
